// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the control unit, the mult/div engines
// and the Hi/Lo sequencer.
interface muldiv_sequencer_if;
  logic        start;
  logic        op_div;
  logic [31:0] operand_b;
  logic        mult_done;
  logic        div_done;
  logic        hilo_read_req;
  logic        mult_start;
  logic        div_start;
  logic        HiLo_load;
  logic        sel_mux_hi;
  logic        sel_mux_lo;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic        timeout;
  logic        hilo_read_stall;

  modport master (
    output start, op_div, operand_b,
    output mult_done, div_done, hilo_read_req,
    input  mult_start, div_start, HiLo_load,
    input  sel_mux_hi, sel_mux_lo, busy, done,
    input  div_zero, timeout, hilo_read_stall
  );

  modport slave (
    input  start, op_div, operand_b,
    input  mult_done, div_done, hilo_read_req,
    output mult_start, div_start, HiLo_load,
    output sel_mux_hi, sel_mux_lo, busy, done,
    output div_zero, timeout, hilo_read_stall
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Launches the mult or div engine, waits for completion or timeout,
// and commits Hi/Lo; stalls MFHI/MFLO while an operation is pending.
module muldiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RUN_MULT, RUN_DIV, COMMIT, FAULT
  } state_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             hold, hold_n;
  logic             zero, zero_n;
  logic             sel, sel_n;
  logic             ms_q, ms_n;
  logic             ds_q, ds_n;
  logic             load_q, load_n;
  logic             done_q, done_n;
  logic             dz_q, dz_n;
  logic             to_q, to_n;
  logic             busy_q, busy_n;
  logic             eng_done;

  assign eng_done = (state == RUN_MULT) ?
                    bus.mult_done : bus.div_done;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hold_n  = hold;
    zero_n  = zero;
    sel_n   = sel;
    ms_n    = 1'b0;
    ds_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          sel_n  = ~bus.op_div;
          cnt_n  = '0;
          hold_n = 1'b0;
          zero_n = 1'b0;
          if (!bus.op_div) begin
            state_n = RUN_MULT;
            ms_n    = 1'b1;
          end else if (bus.operand_b == 32'd0) begin
            // extra FAULT cycle: flags land two cycles after accept
            state_n = FAULT;
            zero_n  = 1'b1;
            hold_n  = 1'b1;
          end else begin
            state_n = RUN_DIV;
            ds_n    = 1'b1;
          end
        end
      end
      RUN_MULT, RUN_DIV: begin
        if (cnt != '1) cnt_n = cnt + 1'b1;
        if (eng_done) state_n = COMMIT;
        else if (cnt == LAST) state_n = FAULT;
      end
      COMMIT: state_n = IDLE;
      FAULT: begin
        if (hold) hold_n = 1'b0;
        else state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    load_n = (state_n == COMMIT);
    done_n = load_n | ((state_n == FAULT) & ~hold_n);
    dz_n   = (state_n == FAULT) & ~hold_n & zero_n;
    to_n   = (state_n == FAULT) & ~hold_n & ~zero_n;
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hold   <= 1'b0;
      zero   <= 1'b0;
      sel    <= 1'b0;
      ms_q   <= 1'b0;
      ds_q   <= 1'b0;
      load_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      to_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      hold   <= hold_n;
      zero   <= zero_n;
      sel    <= sel_n;
      ms_q   <= ms_n;
      ds_q   <= ds_n;
      load_q <= load_n;
      done_q <= done_n;
      dz_q   <= dz_n;
      to_q   <= to_n;
      busy_q <= busy_n;
    end
  end

  assign bus.mult_start = ms_q;
  assign bus.div_start  = ds_q;
  assign bus.HiLo_load  = load_q;
  assign bus.sel_mux_hi = sel;
  assign bus.sel_mux_lo = sel;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.div_zero   = dz_q;
  assign bus.timeout    = to_q;
  assign bus.hilo_read_stall =
    bus.hilo_read_req & (busy_q | bus.start);

endmodule
